// File: rtl/w_reg_writer_pkg.sv
// w_reg_writer_pkg: write-data source and load-type codes shared by the controller and the W stage.
package w_reg_writer_pkg;
  typedef enum logic [2:0] {
    WD_ALU = 3'd0,
    WD_DM  = 3'd1,
    WD_PC8 = 3'd2,
    WD_MDU = 3'd3
  } wdSel_e;
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } loadType_e;
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;
  typedef struct packed {
    logic        regWrite;
    logic [4:0]  regAddr;
    logic [31:0] data;
    logic [31:0] pc;
  } wReg_t;
  localparam logic [31:0] PC8_OFFSET = 32'd8;
  function automatic logic loadTypeLegal(input logic [2:0] loadType);
    return loadType <= LD_HU;
  endfunction
endpackage

// File: rtl/w_reg_writer_load_ext.sv
// w_load_ext: combinational byte/halfword select and sign/zero extension of an aligned load word.
module w_load_ext
  import w_reg_writer_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadType,
  output logic [31:0] extWord
);
  logic [31:0] shifted;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  always_comb begin
    shifted = word >> {offset, 3'b000};
    byteSel = shifted[7:0];
    halfSel = offset[1] ? word[31:16] : word[15:0];
    extWord = loadType == LD_W  ? word :
              loadType == LD_B  ? {{24{byteSel[7]}}, byteSel} :
              loadType == LD_BU ? {24'b0, byteSel} :
              loadType == LD_H  ? {{16{halfSel[15]}}, halfSel} :
              loadType == LD_HU ? {16'b0, halfSel} : 32'b0;
  end
endmodule

// File: rtl/w_reg_writer.sv
// w_reg_writer: M->W pipeline register producing the GRF write port and a retired-instruction count.
// Optional macro W_WB_TRACE_EN prints each committed register write.
module w_reg_writer
  import w_reg_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic        M_RegWrite,
  input  logic [4:0]  M_RegAddr,
  input  logic [2:0]  M_WDSel,
  input  logic [2:0]  M_LoadType,
  input  logic [1:0]  M_ByteOff,
  input  logic [31:0] M_ALUResult,
  input  logic [31:0] M_DMRData,
  input  logic [31:0] M_MDUResult,
  input  logic [31:0] M_PC,
  input  logic        W_stall,
  input  logic        W_flush,
  output logic        CU_EN_RegWrite,
  output logic [4:0]  WriteRegAddr,
  output logic [31:0] WriteData,
  output logic [31:0] W_PC,
  output logic        W_valid,
  output logic [31:0] RetireCount
);
  slot_e       state, stateNext;
  wReg_t       wReg, wRegNext;
  logic [31:0] retireCount, loadData, selData;
  logic        legal, retire;

  w_load_ext uLoadExt (
    .word     (M_DMRData),
    .offset   (M_ByteOff),
    .loadType (M_LoadType),
    .extWord  (loadData)
  );

  // Reserved source or load codes commit nothing: zero data, write enable dropped.
  always_comb begin
    legal     = M_WDSel == WD_ALU || M_WDSel == WD_PC8 || M_WDSel == WD_MDU ||
                (M_WDSel == WD_DM && loadTypeLegal(M_LoadType));
    selData   = M_WDSel == WD_ALU ? M_ALUResult :
                M_WDSel == WD_DM  ? loadData :
                M_WDSel == WD_PC8 ? M_PC + PC8_OFFSET :
                M_WDSel == WD_MDU ? M_MDUResult : 32'b0;
    stateNext = W_flush ? EMPTY : W_stall ? state : (M_valid ? FULL : EMPTY);
    wRegNext  = W_flush ? wReg_t'('0) :
                W_stall ? wReg :
                wReg_t'{regWrite: M_RegWrite && legal, regAddr: M_RegAddr,
                        data: legal ? selData : 32'b0, pc: M_PC};
    retire    = state == FULL && !W_stall && !W_flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      wReg        <= '0;
      retireCount <= '0;
    end else begin
      state       <= stateNext;
      wReg        <= wRegNext;
      retireCount <= retireCount + {31'b0, retire};
    end
  end

  assign W_valid        = state == FULL;
  assign CU_EN_RegWrite = W_valid && wReg.regWrite && (wReg.regAddr != 5'd0);
  assign WriteRegAddr   = wReg.regAddr;
  assign WriteData      = wReg.data;
  assign W_PC           = wReg.pc;
  assign RetireCount    = retireCount;

`ifdef W_WB_TRACE_EN
  always @(posedge clk) begin
    if (CU_EN_RegWrite && !W_stall)
      $display("@%h: $%d <= %h", W_PC, WriteRegAddr, WriteData);
  end
`endif
endmodule

// File: doc/w_reg_writer.md
W_REG_WRITER -- requirements
Module: w_reg_writer

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- M_valid  in  1  M-stage slot holds a real instruction.
- M_RegWrite  in  1  instruction writes GRF.
- M_RegAddr  in  5  destination register.
- M_WDSel  in  3  write-data source: 0 ALU, 1 DM, 2 PC+8, 3 MDU; other codes reserved.
- M_LoadType  in  3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu.
- M_ByteOff  in  2  load address bits [1:0].
- M_ALUResult, M_DMRData, M_MDUResult  in  32 each  candidate data; M_DMRData is the raw aligned word.
- M_PC  in  32  instruction address.
- W_stall  in  1  hold the W register.
- W_flush  in  1  load a bubble.
- CU_EN_RegWrite  out  1  GRF write enable.
- WriteRegAddr  out  5  GRF write address.
- WriteData  out  32  GRF write data.
- W_PC  out  32  retiring instruction address.
- W_valid  out  1  W slot occupied.
- RetireCount  out  32  retired-instruction count.
REQ-002 SHALL use one clock; reset is asynchronous and active-high, with ports named clk and reset.

Function
REQ-003 SHALL register the M inputs into the W register on each rising clk edge; outputs are driven from this register, giving 1-cycle latency from M to GRF write.
REQ-004 SHALL keep a slot state with two values: EMPTY (W_valid=0) and FULL (W_valid=1).
- EMPTY to FULL on an edge with M_valid=1, W_stall=0, W_flush=0.
- FULL to EMPTY on an edge with M_valid=0 or W_flush=1.
REQ-005 SHALL hold every W register field unchanged while W_stall=1 and W_flush=0.
REQ-006 SHALL load a bubble (all fields zero) when W_flush=1; flush beats stall.
REQ-007 SHALL drive CU_EN_RegWrite = W_valid AND registered RegWrite AND (WriteRegAddr != 0).
REQ-008 SHALL select and extend the write data before the register, so WriteData is a register output with no combinational path from M inputs.
REQ-009 Load extension, byte selected by M_ByteOff, halfword by M_ByteOff[1]:
- lb sign-extends the byte; lbu zero-extends it.
- lh sign-extends the halfword; lhu zero-extends it.
- lw passes the word; a nonzero offset is ignored for lw.
REQ-010 SHALL give PC+8 as M_PC+8 modulo 2^32.
REQ-011 SHALL write reserved M_WDSel or M_LoadType codes as 0 with the write enable suppressed.
REQ-012 RetireCount SHALL add 1 on each edge where the slot leaves FULL with W_stall=0 and W_flush=0, and wrap from FFFF_FFFF to 0.
REQ-013 A FULL slot that is flushed SHALL NOT add to RetireCount.

Reset
REQ-014 reset SHALL clear every output immediately, independent of clk: CU_EN_RegWrite=0, WriteRegAddr=0, WriteData=0, W_PC=0, W_valid=0, RetireCount=0, state EMPTY.
REQ-015 Reset asserted mid-stall or mid-flush SHALL take priority; the first edge after deassertion SHALL sample M normally.

Configuration
REQ-016 Macro W_WB_TRACE_EN, when defined, SHALL print "@%h: $%d <= %h" (W_PC, WriteRegAddr, WriteData) at each rising edge where CU_EN_RegWrite=1 and W_stall=0.
REQ-017 When W_WB_TRACE_EN is undefined, no trace logic or simulation output SHALL exist; function is otherwise identical.

Structure
REQ-018 A shared package SHALL hold the WDSel codes (WD_ALU, WD_DM, WD_PC8, WD_MDU) and LoadType codes (LD_W, LD_B, LD_BU, LD_H, LD_HU); these are shared with the controller.
REQ-019 Load extension SHALL be a sub-module w_load_ext (word, offset, type in; extended word out), purely combinational.

Verification
REQ-020 The bench SHALL cover these scenarios:
- lb, M_DMRData=0x12_85_34_56, ByteOff=2 -> next cycle WriteData=0xFFFF_FF85; lbu gives 0x0000_0085.
- lh, M_DMRData=0x8001_7FFF, ByteOff=0 -> WriteData=0x0000_7FFF; ByteOff=2 gives 0xFFFF_8001.
- jal, WDSel=2, M_PC=0x0000_3000, RegAddr=31 -> WriteData=0x0000_3008, CU_EN_RegWrite=1; RegAddr=0 gives enable 0.
- Stall 3 cycles with W holding addr 5, data 0xA -> outputs constant; RetireCount increases by exactly 1 after release.
- W_flush=1 together with W_stall=1 -> next edge W_valid=0, CU_EN_RegWrite=0, RetireCount unchanged.
- Preload RetireCount 0xFFFF_FFFF, retire one instruction -> RetireCount=0; then pulse reset between edges -> all outputs 0 before the next edge.
